nn_mem_arbiter: RTL and testbench
=================================

NN_MEM_ARBITER -- requirements
Module: nn_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8, the read lanes per memory per fetch grant.
REQ-002 SHALL have parameter MEM_LAT, default 1, the SRAM read latency in cycles; only 1 is supported.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on rising edge.
  reset  in  1  asynchronous, active-high reset.
  memory_rqt_fp  in  1  fetch_populate request.
  cmem_addr_arbiter  in  8x17 (Caddr)  fetch config-mem read addresses.
  dmem_addr_arbiter  in  8x17 (Maddr)  fetch data-mem read addresses.
  grant_fp  out  1  fetch grant pulse.
  cmem_data_arbiter  out  8x32 (Cdata)  config-mem read data to fetch.
  dmem_data_arbiter  out  8x32 (Mdata)  data-mem read data to fetch.
  wb_req  in  1  writeback request (one neuron output word).
  wb_addr  in  17 (Maddr)  writeback address.
  wb_data  in  32 (Mdata)  writeback data.
  grant_wb  out  1  writeback grant pulse.
  mem_ready  in  1  memories accept a new access this cycle.
  cmem_rd_addr  out  8x17  config SRAM read addresses.
  cmem_rd_data  in  8x32  config SRAM read data, MEM_LAT after address.
  dmem_rd_addr  out  8x17  data SRAM read addresses.
  dmem_rd_data  in  8x32  data SRAM read data, MEM_LAT after address.
  dmem_we  out  1  data SRAM write enable.
  dmem_wr_addr  out  17  data SRAM write address.
  dmem_wr_data  out  32  data SRAM write data.

Function
REQ-004 SHALL grant at most one requester per cycle: grant_fp and grant_wb SHALL never be high together.
REQ-005 SHALL assert a grant only in a cycle where that requester's request is high and mem_ready=1; each grant SHALL be a one-cycle pulse per accepted access.
REQ-006 In a grant_fp cycle N, SHALL drive cmem_rd_addr/dmem_rd_addr combinationally from cmem_addr_arbiter/dmem_addr_arbiter; outside fetch-grant cycles, read addresses SHALL hold their last granted values.
REQ-007 In cycle N+1, SHALL present cmem_rd_data/dmem_rd_data on cmem_data_arbiter/dmem_data_arbiter and capture them into hold registers.
REQ-008 SHALL drive cmem_data_arbiter/dmem_data_arbiter from the hold registers in all other cycles, until the response cycle of the next fetch grant.
REQ-009 Lanes SHALL be returned unmodified and in lane order; no data-dependent masking is applied.
REQ-010 In a grant_wb cycle, SHALL assert dmem_we=1 with dmem_wr_addr=wb_addr and dmem_wr_data=wb_data; dmem_we SHALL be 0 in every other cycle.
REQ-011 FSM states:
  IDLE: no response pending.
  RESP: fetch response cycle; entered the cycle after grant_fp, left after one cycle.
  Grants SHALL be permitted in both IDLE and RESP, so back-to-back fetch grants stream data with no gap.
REQ-012 A write granted in the RESP cycle SHALL NOT alter the data returned in that cycle: a read to the same address returns the pre-write value.
REQ-013 With mem_ready=0, SHALL issue no grant, keep dmem_we=0, and keep the hold registers unchanged; a RESP already in flight SHALL still complete.
REQ-014 Requests SHALL be level-sensitive; a requester whose request is not granted keeps it asserted with stable addresses and data.

Reset
REQ-015 On reset, SHALL asynchronously force:
  grant_fp=0, grant_wb=0, dmem_we=0;
  FSM=IDLE;
  hold registers, cmem_rd_addr, dmem_rd_addr, dmem_wr_addr, dmem_wr_data = 0;
  cmem_data_arbiter=0, dmem_data_arbiter=0;
  round-robin pointer = writeback-favoured.
REQ-016 Reset asserted during RESP SHALL abort the response; no captured data survives reset.

Configuration
REQ-017 With macro NN_ARB_RR_EN defined, when both requests are pending, SHALL grant the requester not granted most recently; after reset the first contended grant goes to writeback.
REQ-018 With NN_ARB_RR_EN undefined, SHALL use fixed priority with writeback always winning over fetch; fetch waits while wb_req=1.

Verification
REQ-019 A bench SHALL cover these directed scenarios:
  - Fetch read: rqt_fp=1, mem_ready=1, cmem lane0 addr 0x00010 holding 0xDEADBEEF -> grant_fp in N; cmem_data_arbiter[0]=0xDEADBEEF in N+1 and held through N+5.
  - Writeback: wb_req=1, wb_addr=0x00200, wb_data=0x12345678 -> grant_wb and dmem_we for exactly one cycle, with that address and data.
  - Contention, NN_ARB_RR_EN defined: both requests held for 4 cycles -> grants wb, fp, wb, fp.
  - Contention, NN_ARB_RR_EN undefined: same stimulus -> wb granted all 4 cycles; grant_fp=0.
  - Read/write hazard: fetch grant reading dmem 0x00200 (=0xAAAA) in N, then wb write 0x5555 granted in N+1 -> dmem_data_arbiter[0]=0xAAAA in N+1.
  - Stall and reset: mem_ready=0 for 3 cycles -> no grants, hold data unchanged; reset in a RESP cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/nn_mem_arbiter.sv
// nn_mem_arbiter: arbitrates one fetch port (NUM_LANES-wide cmem/dmem reads)
// and one writeback port (single dmem write) onto shared SRAMs.
// Ports: fetch req/addrs -> grant_fp, cmem/dmem_data_arbiter (N+1, then held);
//   wb req/addr/data -> grant_wb, dmem_we/wr_addr/wr_data (same cycle);
//   mem_ready gates all grants; SRAM read ports have one cycle latency.
// Build option: define NN_ARB_RR_EN for round-robin on contention,
//   otherwise writeback has fixed priority.
module nn_mem_arbiter #(
   parameter int NUM_LANES = 8,
   parameter int MEM_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    memory_rqt_fp,
   input  logic [NUM_LANES*17-1:0] cmem_addr_arbiter,
   input  logic [NUM_LANES*17-1:0] dmem_addr_arbiter,
   output logic                    grant_fp,
   output logic [NUM_LANES*32-1:0] cmem_data_arbiter,
   output logic [NUM_LANES*32-1:0] dmem_data_arbiter,
   input  logic                    wb_req,
   input  logic [16:0]             wb_addr,
   input  logic [31:0]             wb_data,
   output logic                    grant_wb,
   input  logic                    mem_ready,
   output logic [NUM_LANES*17-1:0] cmem_rd_addr,
   input  logic [NUM_LANES*32-1:0] cmem_rd_data,
   output logic [NUM_LANES*17-1:0] dmem_rd_addr,
   input  logic [NUM_LANES*32-1:0] dmem_rd_data,
   output logic                    dmem_we,
   output logic [16:0]             dmem_wr_addr,
   output logic [31:0]             dmem_wr_data
);

   if (MEM_LAT != 1) begin : g_lat_chk
      $error("nn_mem_arbiter: only MEM_LAT=1 is supported");
   end

   typedef enum logic {IDLE, RESP} state_t;

   state_t                    state_q, state_d;
   logic [NUM_LANES*17-1:0]   cmem_addr_q, cmem_addr_d;
   logic [NUM_LANES*17-1:0]   dmem_addr_q, dmem_addr_d;
   logic [NUM_LANES*32-1:0]   cmem_hold_q, cmem_hold_d;
   logic [NUM_LANES*32-1:0]   dmem_hold_q, dmem_hold_d;
   logic [16:0]               wr_addr_q, wr_addr_d;
   logic [31:0]               wr_data_q, wr_data_d;
   logic                      gnt_fp, gnt_wb;

`ifdef NN_ARB_RR_EN
   // 1: writeback wins the next contended cycle
   logic rr_wb_q, rr_wb_d;
`endif

   // Grants are combinational; reset also masks them so every output
   // collapses to its (zeroed) registered value while reset is high.
   always_comb begin
      gnt_fp = 1'b0;
      gnt_wb = 1'b0;
      if (mem_ready && !reset) begin
`ifdef NN_ARB_RR_EN
         if (wb_req && memory_rqt_fp) begin
            gnt_wb = rr_wb_q;
            gnt_fp = !rr_wb_q;
         end else begin
            gnt_wb = wb_req;
            gnt_fp = memory_rqt_fp;
         end
`else
         gnt_wb = wb_req;
         gnt_fp = memory_rqt_fp && !wb_req;
`endif
      end
   end

`ifdef NN_ARB_RR_EN
   always_comb begin
      rr_wb_d = rr_wb_q;
      if (gnt_fp) rr_wb_d = 1'b1;
      if (gnt_wb) rr_wb_d = 1'b0;
   end
`endif

   // Response data is live SRAM data in RESP; the SRAM read happened at the
   // grant edge, so a write granted in RESP cannot disturb it.
   always_comb begin
      state_d           = gnt_fp ? RESP : IDLE;
      cmem_rd_addr      = gnt_fp ? cmem_addr_arbiter : cmem_addr_q;
      dmem_rd_addr      = gnt_fp ? dmem_addr_arbiter : dmem_addr_q;
      cmem_addr_d       = cmem_rd_addr;
      dmem_addr_d       = dmem_rd_addr;
      cmem_data_arbiter = (state_q == RESP) ? cmem_rd_data : cmem_hold_q;
      dmem_data_arbiter = (state_q == RESP) ? dmem_rd_data : dmem_hold_q;
      cmem_hold_d       = cmem_data_arbiter;
      dmem_hold_d       = dmem_data_arbiter;
      dmem_wr_addr      = gnt_wb ? wb_addr : wr_addr_q;
      dmem_wr_data      = gnt_wb ? wb_data : wr_data_q;
      wr_addr_d         = dmem_wr_addr;
      wr_data_d         = dmem_wr_data;
   end

   assign grant_fp = gnt_fp;
   assign grant_wb = gnt_wb;
   assign dmem_we  = gnt_wb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmem_addr_q <= '0;
         dmem_addr_q <= '0;
         cmem_hold_q <= '0;
         dmem_hold_q <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmem_addr_q <= cmem_addr_d;
         dmem_addr_q <= dmem_addr_d;
         cmem_hold_q <= cmem_hold_d;
         dmem_hold_q <= dmem_hold_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

`ifdef NN_ARB_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_wb_q <= 1'b1;
      else       rr_wb_q <= rr_wb_d;
   end
`endif

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed bench for nn_mem_arbiter with a 1-cycle-latency SRAM model.
// Table of arbitration vectors plus multi-cycle scenario sequences.
module tb_nn_mem_arbiter;

   localparam int NL = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            memory_rqt_fp;
   logic [NL*17-1:0] cmem_addr_arbiter, dmem_addr_arbiter;
   logic            grant_fp, grant_wb;
   logic [NL*32-1:0] cmem_data_arbiter, dmem_data_arbiter;
   logic            wb_req;
   logic [16:0]     wb_addr;
   logic [31:0]     wb_data;
   logic            mem_ready;
   logic [NL*17-1:0] cmem_rd_addr, dmem_rd_addr;
   logic [NL*32-1:0] cmem_rd_data, dmem_rd_data;
   logic            dmem_we;
   logic [16:0]     dmem_wr_addr;
   logic [31:0]     dmem_wr_data;

   logic [31:0] cmem [1024];
   logic [31:0] dmem [1024];
   logic        pk_c, pk_d;
   logic [9:0]  pk_a;
   logic [31:0] pk_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nn_mem_arbiter #(.NUM_LANES(NL), .MEM_LAT(1)) dut (
      .clk(clk), .reset(reset), .memory_rqt_fp(memory_rqt_fp),
      .cmem_addr_arbiter(cmem_addr_arbiter),
      .dmem_addr_arbiter(dmem_addr_arbiter),
      .grant_fp(grant_fp),
      .cmem_data_arbiter(cmem_data_arbiter),
      .dmem_data_arbiter(dmem_data_arbiter),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .grant_wb(grant_wb), .mem_ready(mem_ready),
      .cmem_rd_addr(cmem_rd_addr), .cmem_rd_data(cmem_rd_data),
      .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
      .dmem_we(dmem_we), .dmem_wr_addr(dmem_wr_addr),
      .dmem_wr_data(dmem_wr_data)
   );

   // SRAM model: read data one cycle after address, read-before-write.
   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         cmem_rd_data[i*32 +: 32] <= cmem[cmem_rd_addr[i*17 +: 10]];
         dmem_rd_data[i*32 +: 32] <= dmem[dmem_rd_addr[i*17 +: 10]];
      end
      if (dmem_we) dmem[dmem_wr_addr[9:0]] <= dmem_wr_data;
      if (pk_c) cmem[pk_a] <= pk_v;
      if (pk_d) dmem[pk_a] <= pk_v;
   end

   typedef struct {
      logic fp, wb, rdy;
      logic e_gfp, e_gwb, e_we;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic poke(input logic is_c, input logic [9:0] a,
                       input logic [31:0] v);
      @(negedge clk);
      pk_c = is_c;
      pk_d = !is_c;
      pk_a = a;
      pk_v = v;
      @(posedge clk);
      #1;
      pk_c = 1'b0;
      pk_d = 1'b0;
   endtask

   initial begin
      logic exp_wb;
      reset = 1'b1;
      memory_rqt_fp = 1'b0;
      wb_req = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      mem_ready = 1'b0;
      pk_c = 1'b0;
      pk_d = 1'b0;
      pk_a = '0;
      pk_v = '0;
      for (int i = 0; i < NL; i++) begin
         cmem_addr_arbiter[i*17 +: 17] = 17'h00010 + 17'(i);
         dmem_addr_arbiter[i*17 +: 17] = 17'h00040 + 17'(i);
      end

      //          fp  wb  rdy  gfp gwb we
      vecs[0] = '{0, 0, 0, 0, 0, 0};
      vecs[1] = '{1, 0, 0, 0, 0, 0};
      vecs[2] = '{0, 1, 0, 0, 0, 0};
      vecs[3] = '{1, 1, 0, 0, 0, 0};
      vecs[4] = '{1, 0, 1, 1, 0, 0};
      vecs[5] = '{0, 1, 1, 0, 1, 1};
      vecs[6] = '{1, 1, 1, 0, 1, 1};
      vecs[7] = '{0, 0, 1, 0, 0, 0};

      for (int i = 0; i < NL; i++) begin
         poke(1'b1, 10'(16 + i), (i == 0) ? 32'hDEADBEEF : 32'hC0DE0000 + i);
         poke(1'b0, 10'(64 + i), 32'hD0000000 + i);
      end
      poke(1'b0, 10'h200, 32'h0000AAAA);

      // Reset state
      #1;
      check("rst grant_fp", grant_fp, 0);
      check("rst grant_wb", grant_wb, 0);
      check("rst dmem_we", dmem_we, 0);
      check("rst wr_addr", dmem_wr_addr, 0);
      check("rst wr_data", dmem_wr_data, 0);
      check("rst cmem_rd_addr0", cmem_rd_addr[16:0], 0);
      check("rst cdata0", cmem_data_arbiter[31:0], 0);
      check("rst ddata0", dmem_data_arbiter[31:0], 0);

      @(negedge clk);
      reset = 1'b0;

      // Arbitration table; requests dropped before every rising edge
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         memory_rqt_fp = vecs[i].fp;
         wb_req = vecs[i].wb;
         mem_ready = vecs[i].rdy;
         wb_addr = 17'h00300;
         #1;
         check($sformatf("vec%0d gfp", i), grant_fp, vecs[i].e_gfp);
         check($sformatf("vec%0d gwb", i), grant_wb, vecs[i].e_gwb);
         check($sformatf("vec%0d we", i), dmem_we, vecs[i].e_we);
         #1;
         memory_rqt_fp = 1'b0;
         wb_req = 1'b0;
         mem_ready = 1'b0;
      end

      // Fetch read
      @(negedge clk);
      memory_rqt_fp = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("fetch grant", grant_fp, 1);
      check("fetch rd_addr0", cmem_rd_addr[16:0], 17'h00010);
      @(posedge clk);
      #1;
      memory_rqt_fp = 1'b0;
      #1;
      check("fetch N+1 grant", grant_fp, 0);
      for (int i = 0; i < NL; i++) begin
         check($sformatf("fetch cdata%0d", i), cmem_data_arbiter[i*32 +: 32],
               (i == 0) ? 32'hDEADBEEF : 32'hC0DE0000 + i);
         check($sformatf("fetch ddata%0d", i), dmem_data_arbiter[i*32 +: 32],
               32'hD0000000 + i);
      end
      check("fetch addr held", cmem_rd_addr[16:0], 17'h00010);
      pk_c = 1'b1;
      pk_a = 10'h010;
      pk_v = 32'h0BADF00D;
      for (int k = 2; k <= 5; k++) begin
         @(posedge clk);
         #1;
         pk_c = 1'b0;
         check($sformatf("fetch hold N+%0d", k), cmem_data_arbiter[31:0],
               32'hDEADBEEF);
      end

      // Writeback
      @(negedge clk);
      wb_req = 1'b1;
      wb_addr = 17'h00200;
      wb_data = 32'h12345678;
      #1;
      check("wb grant", grant_wb, 1);
      check("wb we", dmem_we, 1);
      check("wb addr", dmem_wr_addr, 32'h00200);
      check("wb data", dmem_wr_data, 32'h12345678);
      check("wb no fp", grant_fp, 0);
      @(posedge clk);
      #1;
      wb_req = 1'b0;
      #1;
      check("wb pulse grant", grant_wb, 0);
      check("wb pulse we", dmem_we, 0);
      check("wb mem", dmem[10'h200], 32'h12345678);

      // Contention from a fresh reset
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      memory_rqt_fp = 1'b1;
      wb_req = 1'b1;
      wb_addr = 17'h00300;
      wb_data = 32'h0;
      mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
`ifdef NN_ARB_RR_EN
         exp_wb = (k % 2 == 0);
`else
         exp_wb = 1'b1;
`endif
         check($sformatf("cont%0d gwb", k), grant_wb, exp_wb);
         check($sformatf("cont%0d gfp", k), grant_fp, !exp_wb);
         @(negedge clk);
      end
      memory_rqt_fp = 1'b0;
      wb_req = 1'b0;

      // Read/write hazard on dmem 0x200
      poke(1'b0, 10'h200, 32'h0000AAAA);
      for (int i = 0; i < NL; i++)
         dmem_addr_arbiter[i*17 +: 17] = 17'h00200;
      @(negedge clk);
      memory_rqt_fp = 1'b1;
      #1;
      check("haz fp grant", grant_fp, 1);
      @(posedge clk);
      #1;
      memory_rqt_fp = 1'b0;
      wb_req = 1'b1;
      wb_addr = 17'h00200;
      wb_data = 32'h00005555;
      #1;
      check("haz wb grant", grant_wb, 1);
      check("haz ddata N+1", dmem_data_arbiter[31:0], 32'h0000AAAA);
      @(posedge clk);
      #1;
      wb_req = 1'b0;
      check("haz hold N+2", dmem_data_arbiter[31:0], 32'h0000AAAA);
      check("haz mem written", dmem[10'h200], 32'h00005555);

      // Stall: live read data is now 0x5555, hold must stay 0xAAAA
      @(negedge clk);
      mem_ready = 1'b0;
      memory_rqt_fp = 1'b1;
      wb_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("stall%0d gfp", k), grant_fp, 0);
         check($sformatf("stall%0d gwb", k), grant_wb, 0);
         check($sformatf("stall%0d we", k), dmem_we, 0);
         check($sformatf("stall%0d hold", k), dmem_data_arbiter[31:0],
               32'h0000AAAA);
      end
      memory_rqt_fp = 1'b0;
      wb_req = 1'b0;
      mem_ready = 1'b1;

      // Reset during RESP
      @(negedge clk);
      memory_rqt_fp = 1'b1;
      @(posedge clk);
      #1;
      memory_rqt_fp = 1'b0;
      #1;
      check("rresp cdata", cmem_data_arbiter[31:0], 32'h0BADF00D);
      reset = 1'b1;
      #1;
      check("rresp cdata0", cmem_data_arbiter[31:0], 0);
      check("rresp ddata0", dmem_data_arbiter[31:0], 0);
      check("rresp rd_addr", cmem_rd_addr[16:0], 0);
      check("rresp wr_addr", dmem_wr_addr, 0);
      check("rresp gfp", grant_fp, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post rst cdata", cmem_data_arbiter[31:0], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
